apb_requester: RTL and testbench

Synthesizable APB initiator that turns single-beat commands from a valid/ready command port into APB3-style SETUP/ACCESS transfers, and returns completion status and read data on a valid/ready response port. It drives the APB signal set that our existing APB slave consumes: PADDR, PWRITE, PSELx, PENABLE, PWDATA, PRDATA, PREADY. It replaces the behavioural initial-block stimulus with a real requester that firmware-facing logic or a bench driver can own. It adds a wait-state timeout so a stuck slave cannot hang the bus.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_requester_if.sv | 41 ++++
 rtl/apb_wait_timer.sv | 31 +++
 rtl/apb_requester.sv | 84 ++++++++
 tb/tb_apb_requester.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding and default bus widths.
// Imported by the requester and by the APB slave.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_req_state_e;

   localparam int APB_ADDR_W_DEF = 12;
   localparam int APB_DATA_W_DEF = 32;

endpackage

// File: rtl/apb_requester_if.sv
// Command port, response port and APB signal set of the requester, bundled in one interface.
// The master view belongs to the requester; the slave view belongs to whoever drives commands and PREADY.
interface apb_requester_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W_DEF,
   parameter int DATA_W = APB_DATA_W_DEF
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_timeout;

   logic [ADDR_W-1:0] PADDR;
   logic              PWRITE;
   logic              PSELx;
   logic              PENABLE;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
             PADDR, PWRITE, PSELx, PENABLE, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
             PADDR, PWRITE, PSELx, PENABLE, PWDATA
   );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the last allowed one; TIMEOUT=0 never expires.
// The counter saturates instead of wrapping.
module apb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt;

   // NOTE: this codebase's reset is active-high, so the sensitivity is posedge PRESETn.
   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         wait_cnt <= '0;
      end else if (clr) begin
         wait_cnt <= '0;
      end else if (inc && (wait_cnt != '1)) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign expired = (TIMEOUT != 0) && (wait_cnt == LAST);

endmodule

// File: rtl/apb_requester.sv
// APB initiator: one command in, one SETUP/ACCESS transfer out, one response back.
// A wait-state timeout aborts transfers to a slave that never raises PREADY.
module apb_requester
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W_DEF,
   parameter int DATA_W  = APB_DATA_W_DEF,
   parameter int TIMEOUT = 16
) (
   input logic            PCLK,
   input logic            PRESETn,
   apb_requester_if.master bus
);

   apb_req_state_e state;
   logic           expired;
   logic           timer_clr;
   logic           timer_inc;

   assign timer_clr = (state == SETUP);
   assign timer_inc = (state == ACCESS) && !bus.PREADY && !expired;

   apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .clr     (timer_clr),
      .inc     (timer_inc),
      .expired (expired)
   );

   // Ready depends on state alone so a command can never be combinationally looped back.
   assign bus.cmd_ready = (state == IDLE) && !PRESETn;

   // NOTE: every register here uses <= so all of them update together from pre-edge values.
   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         state           <= IDLE;
         bus.PADDR       <= {ADDR_W{1'b0}};
         bus.PWRITE      <= 1'b0;
         bus.PSELx       <= 1'b0;
         bus.PENABLE     <= 1'b0;
         bus.PWDATA      <= {DATA_W{1'b0}};
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rdata   <= {DATA_W{1'b0}};
         bus.rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  bus.PADDR   <= bus.cmd_addr;
                  bus.PWRITE  <= bus.cmd_write;
                  bus.PWDATA  <= bus.cmd_write ? bus.cmd_wdata : {DATA_W{1'b0}};
                  bus.PSELx   <= 1'b1;
                  bus.PENABLE <= 1'b0;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               bus.PENABLE <= 1'b1;
               state       <= ACCESS;
            end
            ACCESS: begin
               // PREADY wins over an expiring counter on the same edge.
               if (bus.PREADY || expired) begin
                  bus.rsp_rdata   <= (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : {DATA_W{1'b0}};
                  bus.rsp_timeout <= !bus.PREADY;
                  bus.PSELx       <= 1'b0;
                  bus.PENABLE     <= 1'b0;
                  bus.rsp_valid   <= 1'b1;
                  state           <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: a transaction-level model predicts every output each cycle,
// and directed scenarios pin the latencies with literal expectations.
`timescale 1ns/1ps
module tb_apb_requester;
   import apb_pkg::*;

   localparam int TO    = 4;
   localparam int STUCK = 1000;

   logic PCLK    = 1'b0;
   logic PRESETn = 1'b1;
   always #5 PCLK = ~PCLK;

   apb_requester_if bus ();
   apb_requester_if bus0 ();

   apb_requester #(.TIMEOUT(TO)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   apb_requester #(.TIMEOUT(0)) dut0 (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus0)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transfer-level model: at accept it computes the completion edge from the slave script.
   int          cyc = 0;
   bit          m_busy = 0, m_rsp_valid = 0, m_write = 0, m_to = 0;
   int          m_acc = -1, m_done = 0, m_ra = 0;
   logic [11:0] m_addr = '0;
   logic [31:0] m_wdata = '0, m_rdata = '0, m_prdata = '0;
   int          cur_ra = 0;
   logic [31:0] cur_prdata = '0;

   always @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         m_busy = 0; m_rsp_valid = 0; m_write = 0; m_to = 0;
         m_acc = -1; m_done = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      end else begin
         cyc++;
         if (!m_busy) begin
            if (bus.cmd_valid) begin
               m_busy   = 1;
               m_acc    = cyc;
               m_addr   = bus.cmd_addr;
               m_write  = bus.cmd_write;
               m_wdata  = bus.cmd_write ? bus.cmd_wdata : 32'h0;
               m_ra     = cur_ra;
               m_prdata = cur_prdata;
               m_to     = (TO != 0) && (cur_ra >= TO);
               m_done   = cyc + 1 + (m_to ? TO : cur_ra + 1);
            end
         end else if (m_rsp_valid) begin
            if (bus.rsp_ready) begin
               m_busy      = 0;
               m_rsp_valid = 0;
            end
         end else if (cyc == m_done) begin
            m_rsp_valid = 1;
            m_rdata     = (m_write || m_to) ? 32'h0 : m_prdata;
         end
      end
   end

   // Scripted slave: PREADY low for m_ra ACCESS cycles; high (and ignorable) outside ACCESS.
   int acc_cnt = 0;
   always @(negedge PCLK) begin
      if (bus.PSELx && bus.PENABLE) begin
         bus.PREADY = (acc_cnt >= m_ra);
         bus.PRDATA = bus.PREADY ? m_prdata : 32'hBAD0_BAD0;
         acc_cnt++;
      end else begin
         acc_cnt    = 0;
         bus.PREADY = 1'b1;
         bus.PRDATA = 32'hBAD0_BAD0;
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge PCLK) begin
      if (cmp_en) begin
         check("cmd_ready", bus.cmd_ready, !m_busy && !PRESETn);
         check("PSELx",     bus.PSELx,     m_busy && (cyc < m_done));
         check("PENABLE",   bus.PENABLE,   m_busy && (cyc > m_acc) && (cyc < m_done));
         check("PADDR",     bus.PADDR,     m_addr);
         check("PWRITE",    bus.PWRITE,    m_write);
         check("PWDATA",    bus.PWDATA,    m_wdata);
         check("rsp_valid", bus.rsp_valid, m_rsp_valid);
         if (m_rsp_valid) begin
            check("rsp_rdata",   bus.rsp_rdata,   m_rdata);
            check("rsp_timeout", bus.rsp_timeout, m_to);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   // Presents a command and returns at the negedge after the accept edge.
   task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input int ra, input logic [31:0] pd, output int t);
      cur_ra        = ra;
      cur_prdata    = pd;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      bus.cmd_valid = 1'b1;
      t = -1;
      for (int i = 0; i < 20 && t < 0; i++) begin
         @(negedge PCLK);
         if (m_busy && (m_acc == cyc)) t = cyc;
      end
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 12'hFFF;
      bus.cmd_wdata = 32'hFFFF_FFFF;
      check("accepted", (t >= 0), 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bus.cmd_valid  = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.rsp_ready  = 1'b1;
      bus0.cmd_valid = 1'b0; bus0.cmd_write = 1'b0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0;
      bus0.rsp_ready = 1'b1; bus0.PREADY = 1'b0; bus0.PRDATA = 32'h1111_1111;

      tick(3);
      check("rst PSELx",     bus.PSELx,     1'b0);
      check("rst PENABLE",   bus.PENABLE,   1'b0);
      check("rst cmd_ready", bus.cmd_ready, 1'b0);
      check("rst rsp_valid", bus.rsp_valid, 1'b0);
      check("rst PADDR",     bus.PADDR,     12'h000);
      check("rst rsp_rdata", bus.rsp_rdata, 32'h0);
      #3 PRESETn = 1'b0;
      #1 check("post-rst cmd_ready", bus.cmd_ready, 1'b1);
      cmp_en = 1'b1;

      // TIMEOUT=0 instance with a stuck slave never completes.
      @(negedge PCLK);
      bus0.cmd_addr = 12'h0AA; bus0.cmd_valid = 1'b1;
      tick(1);
      bus0.cmd_valid = 1'b0;
      check("t0 PSELx at accept", bus0.PSELx, 1'b1);
      tick(40);
      check("t0 PSELx held",   bus0.PSELx,     1'b1);
      check("t0 PENABLE held", bus0.PENABLE,   1'b1);
      check("t0 no response",  bus0.rsp_valid, 1'b0);
      check("t0 cmd_ready",    bus0.cmd_ready, 1'b0);

      // Write, zero wait states.
      issue(1'b1, 12'h000, 32'h0000_0002, 0, 32'h1234_5678, t);
      check("w0 PSELx@T",   bus.PSELx,   1'b1);
      check("w0 PENABLE@T", bus.PENABLE, 1'b0);
      tick(1);
      check("w0 PENABLE@T+1", bus.PENABLE, 1'b1);
      check("w0 PADDR",       bus.PADDR,   12'h000);
      check("w0 PWDATA",      bus.PWDATA,  32'h0000_0002);
      tick(1);
      check("w0 model done",    m_done - t,      2);
      check("w0 rsp_valid@T+2", bus.rsp_valid,   1'b1);
      check("w0 PSELx@T+2",     bus.PSELx,       1'b0);
      check("w0 rsp_timeout",   bus.rsp_timeout, 1'b0);
      check("w0 rsp_rdata",     bus.rsp_rdata,   32'h0);
      tick(1);
      check("w0 rsp cleared", bus.rsp_valid, 1'b0);

      // Read with three wait states; success lands on the last allowed ACCESS cycle.
      issue(1'b0, 12'h010, 32'h0, 3, 32'hDEAD_BEEF, t);
      for (int k = 0; k < 5; k++) begin
         check("rd PADDR stable", bus.PADDR,     12'h010);
         check("rd no rsp yet",   bus.rsp_valid, 1'b0);
         tick(1);
      end
      check("rd rsp_valid@T+5", bus.rsp_valid,   1'b1);
      check("rd rsp_rdata",     bus.rsp_rdata,   32'hDEAD_BEEF);
      check("rd rsp_timeout",   bus.rsp_timeout, 1'b0);
      tick(1);

      // Timeout: stuck slave, abort after four ACCESS cycles.
      issue(1'b0, 12'h020, 32'h0, STUCK, 32'h7777_7777, t);
      tick(4);
      check("to PSELx@T+4",   bus.PSELx,     1'b1);
      check("to PENABLE@T+4", bus.PENABLE,   1'b1);
      check("to no rsp@T+4",  bus.rsp_valid, 1'b0);
      tick(1);
      check("to model done",   m_done - t,      5);
      check("to PSELx@T+5",    bus.PSELx,       1'b0);
      check("to PENABLE@T+5",  bus.PENABLE,     1'b0);
      check("to rsp_valid",    bus.rsp_valid,   1'b1);
      check("to rsp_timeout",  bus.rsp_timeout, 1'b1);
      check("to rsp_rdata",    bus.rsp_rdata,   32'h0);
      tick(1);

      // Boundary: PREADY on the exact timeout cycle wins; one cycle later times out.
      issue(1'b0, 12'h030, 32'h0, 3, 32'h0000_0005, t);
      tick(5);
      check("bd rsp_valid",   bus.rsp_valid,   1'b1);
      check("bd rsp_timeout", bus.rsp_timeout, 1'b0);
      check("bd rsp_rdata",   bus.rsp_rdata,   32'h0000_0005);
      tick(1);
      issue(1'b0, 12'h034, 32'h0, 4, 32'h0000_0009, t);
      tick(5);
      check("bd+1 rsp_timeout", bus.rsp_timeout, 1'b1);
      check("bd+1 rsp_rdata",   bus.rsp_rdata,   32'h0);
      tick(1);

      // Backpressure with a second command queued behind the first.
      bus.rsp_ready = 1'b0;
      issue(1'b1, 12'h040, 32'hA5A5_A5A5, 0, 32'h3333_3333, t);
      tick(2);
      check("bp rsp_valid", bus.rsp_valid, 1'b1);
      cur_ra = 1; cur_prdata = 32'hCAFE_F00D;
      bus.cmd_write = 1'b0; bus.cmd_addr = 12'h044; bus.cmd_wdata = 32'h0; bus.cmd_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         check("bp cmd_ready low", bus.cmd_ready,   1'b0);
         check("bp rsp_valid",     bus.rsp_valid,   1'b1);
         check("bp rsp_timeout",   bus.rsp_timeout, 1'b0);
         check("bp PADDR",         bus.PADDR,       12'h040);
      end
      bus.rsp_ready = 1'b1;
      tick(1);
      check("bp handshake",     bus.rsp_valid, 1'b0);
      check("bp cmd_ready",     bus.cmd_ready, 1'b1);
      check("bp PSELx idle",    bus.PSELx,     1'b0);
      tick(1);
      bus.cmd_valid = 1'b0;
      check("b2b PSELx",  bus.PSELx,  1'b1);
      check("b2b PADDR",  bus.PADDR,  12'h044);
      check("b2b PWRITE", bus.PWRITE, 1'b0);
      tick(3);
      check("b2b rsp_valid", bus.rsp_valid, 1'b1);
      check("b2b rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
      tick(1);

      // Reset in the middle of ACCESS, then a clean write.
      issue(1'b0, 12'h050, 32'h0, STUCK, 32'h4444_4444, t);
      tick(2);
      check("rm PENABLE before", bus.PENABLE, 1'b1);
      #2 PRESETn = 1'b1;
      #1;
      check("rm PSELx",        bus.PSELx,     1'b0);
      check("rm PENABLE",      bus.PENABLE,   1'b0);
      check("rm rsp_valid",    bus.rsp_valid, 1'b0);
      check("rm PADDR",        bus.PADDR,     12'h000);
      check("rm cmd_ready",    bus.cmd_ready, 1'b0);
      check("rm dut0 PSELx",   bus0.PSELx,    1'b0);
      @(negedge PCLK);
      #3 PRESETn = 1'b0;
      #1;
      check("rm cmd_ready after", bus.cmd_ready,  1'b1);
      check("rm dut0 cmd_ready",  bus0.cmd_ready, 1'b1);
      issue(1'b1, 12'h060, 32'h1357_9BDF, 1, 32'h5555_5555, t);
      tick(3);
      check("rm wr rsp_valid",   bus.rsp_valid,   1'b1);
      check("rm wr rsp_timeout", bus.rsp_timeout, 1'b0);
      check("rm wr PWDATA",      bus.PWDATA,      32'h1357_9BDF);
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
